logic_unit_arbiter: RTL and testbench
=====================================

Name: logic_unit_arbiter

Overview:
- Shares one bitwise logic unit (word-wide AND/OR/XOR datapath) between two requesters.
- Each requester uses valid/ready handshakes on both the request and response channels.
- The block arbitrates round-robin, latches operands, sequences one operation at a time through the shared datapath, and holds the result until the owning requester accepts it.
- Sits between the ALU front-end issue ports and the logic datapath.

Parameters:
- w, 16, operand/result width in bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 request accepted this cycle when high with req0_valid.
- req0_op  input  2  requester 0 opcode: 00 AND, 01 OR, 10 XOR, 11 reserved.
- req0_x  input  w  requester 0 operand x.
- req0_y  input  w  requester 0 operand y.
- req1_valid, req1_ready, req1_op, req1_x, req1_y: same as above, for requester 1.
- resp0_valid  output  1  result available for requester 0.
- resp0_ready  input  1  requester 0 accepts the result.
- resp1_valid  output  1  result available for requester 1.
- resp1_ready  input  1  requester 1 accepts the result.
- resp_z  output  w  result word, shared by both response channels.
- resp_err  output  1  the operation used reserved opcode 11.

Behaviour:
- State machine states: IDLE, EXEC, RESP. Registers: operands x_q/y_q, op_q, owner (1 bit), prio (1 bit), resp_z, resp_err.
- Reset (rst=1 at a rising edge):
  - state=IDLE, prio=0, owner=0.
  - resp_z=0, resp_err=0, x_q=y_q=0, op_q=0.
  - While rst is high, req0_ready=req1_ready=0 and resp0_valid=resp1_valid=0.
- Grant in IDLE (combinational):
  - Only req0_valid high: req0_ready=1.
  - Only req1_valid high: req1_ready=1.
  - Both high: ready goes to the requester indexed by prio.
  - Neither high: both ready=0.
  - At most one ready is high in any cycle. Both ready=0 in EXEC and RESP.
  - ready may depend on valid. Requesters must not make valid depend on ready.
- Accept (IDLE, valid&ready): latch x, y, op of the granted requester, set owner=granted index, set prio=~granted index, go to EXEC.
- EXEC (exactly 1 cycle):
  - resp_z <= op_q-selected word_and/word_or/word_xor of x_q, y_q.
  - If op_q=11: resp_z <= 0 and resp_err <= 1; otherwise resp_err <= 0.
  - Go to RESP.
- RESP:
  - resp{owner}_valid=1; the other resp_valid=0.
  - resp_z and resp_err are held stable.
  - When resp{owner}_ready=1: go to IDLE next cycle. The ready of the non-owner is ignored.
- Latency and throughput:
  - Accept at cycle t, EXEC at t+1, resp_valid first high at t+2.
  - With resp_ready tied high, the next accept is possible at t+3, giving a throughput of 1 op per 3 cycles.
- Request inputs are ignored outside the accept cycle. Changes to x/y/op after acceptance do not affect the result.
- Outside RESP, resp_z and resp_err keep their last values.
- Starvation: under continuous contention, grants strictly alternate 0,1,0,1...
- A request from one requester with no contention is granted regardless of prio. prio still updates to ~granted.
- Reset mid-operation (EXEC or RESP):
  - The operation is abandoned and no response is issued.
  - All registers take their reset values on that edge.
  - resp_valid is low in the cycle after the reset edge.
- Unknown or illegal state encodings recover to IDLE.

Test Plan:
- Single AND: req0 op=00 x=F0F0 y=0FF0, resp0_ready=1 -> req0_ready=1 at t, resp0_valid=1 at t+2 only, resp_z=00F0, resp_err=0, resp1_valid=0.
- Contention: req0 (OR A5A5|5A00) and req1 (XOR FFFF^1234) valid together from reset, both resp_ready=1 -> req0 served first (resp_z=FFA5), req1 accepted 3 cycles later (resp_z=EDCB on resp1). Kept valid for 6 ops, grants alternate 0,1,0,1,0,1.
- Backpressure: req1 op=01 x=0001 y=0002, resp1_ready=0 for 5 cycles then 1 -> resp1_valid and resp_z=0003 held stable all 6 cycles; req0_ready stays 0 throughout despite req0_valid=1; req0 accepted the cycle after return to IDLE.
- Operand change after accept: req0 op=10 x=00FF y=0F0F, x changed to FFFF at t+1 -> resp_z=0FF0.
- Reserved op: req1 op=11 x=1234 y=5678 -> resp_z=0000, resp_err=1. Next op 00 with FFFF&00FF -> resp_z=00FF, resp_err=0.
- Reset mid-op: rst=1 during EXEC of an accepted req0 -> resp0_valid never asserts, resp_z=0. Next contended request is granted to req0 (prio=0).

Source files
------------

// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : logic_unit_arbiter
//  Description : Shares one word-wide bitwise logic unit (AND/OR/XOR) between
//                two requesters. Round-robin arbitration in IDLE, operands
//                latched on accept, one EXEC cycle through the datapath, and
//                the result held in RESP until the owning requester takes it.
//  Ports       : clk, rst                  - clock, sync active-high reset
//                reqN_valid/ready          - request handshake, N = 0,1
//                reqN_op/x/y               - opcode (00 AND, 01 OR, 10 XOR,
//                                            11 reserved) and operands
//                respN_valid/ready         - response handshake, N = 0,1
//                resp_z                    - shared result word
//                resp_err                  - result came from reserved opcode
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_arbiter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [1:0]   req0_op,
  input  logic [W-1:0] req0_x,
  input  logic [W-1:0] req0_y,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [1:0]   req1_op,
  input  logic [W-1:0] req1_x,
  input  logic [W-1:0] req1_y,
  output logic         resp0_valid,
  input  logic         resp0_ready,
  output logic         resp1_valid,
  input  logic         resp1_ready,
  output logic [W-1:0] resp_z,
  output logic         resp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] c_op_and = 2'b00;
  localparam logic [1:0] c_op_or  = 2'b01;
  localparam logic [1:0] c_op_xor = 2'b10;

  state_t         r_state;
  state_t         w_state_next;
  logic [W-1:0]   r_x_q;
  logic [W-1:0]   r_y_q;
  logic [1:0]     r_op_q;
  logic           r_owner;
  logic           r_prio;
  logic [W-1:0]   r_resp_z;
  logic           r_resp_err;

  logic           w_grant_valid;
  logic           w_grant_idx;
  logic           w_accept;
  logic           w_resp_ready;
  logic [W-1:0]   w_word_and;
  logic [W-1:0]   w_word_or;
  logic [W-1:0]   w_word_xor;
  logic [W-1:0]   w_exec_z;
  logic           w_exec_err;

  // --------------------------------------------------------------------------
  // Grant: only offered in IDLE and never while reset is asserted. Under
  // contention prio picks the winner; a lone requester wins regardless.
  // --------------------------------------------------------------------------
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_idx   = 1'b0;
    if ((r_state == IDLE) && !rst) begin
      if (req0_valid && req1_valid) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = r_prio;
      end else if (req0_valid) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = 1'b0;
      end else if (req1_valid) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = 1'b1;
      end
    end
  end

  assign req0_ready = w_grant_valid && (w_grant_idx == 1'b0);
  assign req1_ready = w_grant_valid && (w_grant_idx == 1'b1);
  // A grant is only issued to a valid requester, so grant implies accept.
  assign w_accept   = w_grant_valid;

  assign resp0_valid  = (r_state == RESP) && !rst && (r_owner == 1'b0);
  assign resp1_valid  = (r_state == RESP) && !rst && (r_owner == 1'b1);
  // Only the owner's ready can retire the response.
  assign w_resp_ready = r_owner ? resp1_ready : resp0_ready;

  assign resp_z   = r_resp_z;
  assign resp_err = r_resp_err;

  // --------------------------------------------------------------------------
  // Shared logic datapath
  // --------------------------------------------------------------------------
  assign w_word_and = r_x_q & r_y_q;
  assign w_word_or  = r_x_q | r_y_q;
  assign w_word_xor = r_x_q ^ r_y_q;

  always_comb begin
    w_exec_z   = '0;
    w_exec_err = 1'b0;
    case (r_op_q)
      c_op_and: w_exec_z = w_word_and;
      c_op_or:  w_exec_z = w_word_or;
      c_op_xor: w_exec_z = w_word_xor;
      default: begin
        w_exec_z   = '0;
        w_exec_err = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic; any unused encoding falls back to IDLE.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = IDLE;
    case (r_state)
      IDLE:    w_state_next = w_accept ? EXEC : IDLE;
      EXEC:    w_state_next = RESP;
      RESP:    w_state_next = w_resp_ready ? IDLE : RESP;
      default: w_state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_x_q      <= '0;
      r_y_q      <= '0;
      r_op_q     <= 2'b00;
      r_owner    <= 1'b0;
      r_prio     <= 1'b0;
      r_resp_z   <= '0;
      r_resp_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == IDLE) && w_accept) begin
        r_x_q   <= w_grant_idx ? req1_x  : req0_x;
        r_y_q   <= w_grant_idx ? req1_y  : req0_y;
        r_op_q  <= w_grant_idx ? req1_op : req0_op;
        r_owner <= w_grant_idx;
        r_prio  <= ~w_grant_idx;
      end
      if (r_state == EXEC) begin
        r_resp_z   <= w_exec_z;
        r_resp_err <= w_exec_err;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_logic_unit_arbiter
//  Description : Directed self-checking bench for logic_unit_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_arbiter;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         req0_valid;
  logic         req0_ready;
  logic [1:0]   req0_op;
  logic [W-1:0] req0_x;
  logic [W-1:0] req0_y;
  logic         req1_valid;
  logic         req1_ready;
  logic [1:0]   req1_op;
  logic [W-1:0] req1_x;
  logic [W-1:0] req1_y;
  logic         resp0_valid;
  logic         resp0_ready;
  logic         resp1_valid;
  logic         resp1_ready;
  logic [W-1:0] resp_z;
  logic         resp_err;

  int total_cnt;
  int bad_cnt;

  logic         exp_idx;
  logic [W-1:0] exp_z;

  logic_unit_arbiter #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_op     (req0_op),
    .req0_x      (req0_x),
    .req0_y      (req0_y),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_op     (req1_op),
    .req1_x      (req1_x),
    .req1_y      (req1_y),
    .resp0_valid (resp0_valid),
    .resp0_ready (resp0_ready),
    .resp1_valid (resp1_valid),
    .resp1_ready (resp1_ready),
    .resp_z      (resp_z),
    .resp_err    (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven here, well clear of it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    total_cnt   = 0;
    bad_cnt     = 0;
    rst         = 1'b1;
    req0_valid  = 1'b1;
    req0_op     = 2'b00;
    req0_x      = '0;
    req0_y      = '0;
    req1_valid  = 1'b1;
    req1_op     = 2'b00;
    req1_x      = '0;
    req1_y      = '0;
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;

    // ---------------- reset ----------------
    step();
    settle();
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    chk("rst_resp0_valid", {31'd0, resp0_valid}, 32'd0);
    chk("rst_resp1_valid", {31'd0, resp1_valid}, 32'd0);
    chk("rst_resp_z", {16'd0, resp_z}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    step();
    rst        = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // ---------------- single AND ----------------
    req0_valid  = 1'b1;
    req0_op     = 2'b00;
    req0_x      = 16'hF0F0;
    req0_y      = 16'h0FF0;
    resp0_ready = 1'b1;
    settle();
    chk("and_req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("and_req1_ready", {31'd0, req1_ready}, 32'd0);
    step();
    req0_valid = 1'b0;
    settle();
    chk("and_exec_ready", {31'd0, req0_ready}, 32'd0);
    chk("and_exec_valid", {31'd0, resp0_valid}, 32'd0);
    step();
    settle();
    chk("and_resp0_valid", {31'd0, resp0_valid}, 32'd1);
    chk("and_resp1_valid", {31'd0, resp1_valid}, 32'd0);
    chk("and_resp_z", {16'd0, resp_z}, 32'h00F0);
    chk("and_resp_err", {31'd0, resp_err}, 32'd0);
    step();
    settle();
    chk("and_after_valid", {31'd0, resp0_valid}, 32'd0);

    // ---------------- contention from reset ----------------
    rst = 1'b1;
    step();
    rst         = 1'b0;
    req0_valid  = 1'b1;
    req0_op     = 2'b01;
    req0_x      = 16'hA5A5;
    req0_y      = 16'h5A00;
    req1_valid  = 1'b1;
    req1_op     = 2'b10;
    req1_x      = 16'hFFFF;
    req1_y      = 16'h1234;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_idx = k[0];
      exp_z   = exp_idx ? 16'hEDCB : 16'hFFA5;
      settle();
      chk("cont_req0_ready", {31'd0, req0_ready}, {31'd0, ~exp_idx});
      chk("cont_req1_ready", {31'd0, req1_ready}, {31'd0, exp_idx});
      step();
      step();
      settle();
      chk("cont_resp0_valid", {31'd0, resp0_valid}, {31'd0, ~exp_idx});
      chk("cont_resp1_valid", {31'd0, resp1_valid}, {31'd0, exp_idx});
      chk("cont_resp_z", {16'd0, resp_z}, {16'd0, exp_z});
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // ---------------- backpressure on requester 1 ----------------
    req1_valid  = 1'b1;
    req1_op     = 2'b01;
    req1_x      = 16'h0001;
    req1_y      = 16'h0002;
    resp1_ready = 1'b0;
    resp0_ready = 1'b1;   // non-owner ready must not retire the response
    settle();
    chk("bp_req1_ready", {31'd0, req1_ready}, 32'd1);
    step();
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    req0_op    = 2'b00;
    req0_x     = 16'hFFFF;
    req0_y     = 16'h00FF;
    settle();
    chk("bp_exec_req0_ready", {31'd0, req0_ready}, 32'd0);
    step();
    for (int c = 0; c < 6; c++) begin
      if (c == 5) resp1_ready = 1'b1;
      settle();
      chk("bp_resp1_valid", {31'd0, resp1_valid}, 32'd1);
      chk("bp_resp0_valid", {31'd0, resp0_valid}, 32'd0);
      chk("bp_resp_z", {16'd0, resp_z}, 32'h0003);
      chk("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
      step();
    end
    settle();
    chk("bp_req0_accept", {31'd0, req0_ready}, 32'd1);
    chk("bp_resp1_low", {31'd0, resp1_valid}, 32'd0);
    step();
    req0_valid = 1'b0;
    step();
    settle();
    chk("bp_req0_resp_valid", {31'd0, resp0_valid}, 32'd1);
    chk("bp_req0_resp_z", {16'd0, resp_z}, 32'h00FF);
    step();

    // ---------------- operand change after accept ----------------
    req0_valid = 1'b1;
    req0_op    = 2'b10;
    req0_x     = 16'h00FF;
    req0_y     = 16'h0F0F;
    settle();
    chk("chg_req0_ready", {31'd0, req0_ready}, 32'd1);
    step();
    req0_valid = 1'b0;
    req0_x     = 16'hFFFF;
    step();
    settle();
    chk("chg_resp0_valid", {31'd0, resp0_valid}, 32'd1);
    chk("chg_resp_z", {16'd0, resp_z}, 32'h0FF0);
    step();

    // ---------------- reserved opcode ----------------
    req1_valid  = 1'b1;
    req1_op     = 2'b11;
    req1_x      = 16'h1234;
    req1_y      = 16'h5678;
    resp1_ready = 1'b1;
    settle();
    chk("rsv_req1_ready", {31'd0, req1_ready}, 32'd1);
    step();
    req1_valid = 1'b0;
    step();
    settle();
    chk("rsv_resp1_valid", {31'd0, resp1_valid}, 32'd1);
    chk("rsv_resp_z", {16'd0, resp_z}, 32'h0000);
    chk("rsv_resp_err", {31'd0, resp_err}, 32'd1);
    step();
    req1_valid = 1'b1;
    req1_op    = 2'b00;
    req1_x     = 16'hFFFF;
    req1_y     = 16'h00FF;
    settle();
    chk("rsv2_req1_ready", {31'd0, req1_ready}, 32'd1);
    step();
    req1_valid = 1'b0;
    step();
    settle();
    chk("rsv2_resp_z", {16'd0, resp_z}, 32'h00FF);
    chk("rsv2_resp_err", {31'd0, resp_err}, 32'd0);
    step();
    settle();
    chk("hold_resp_z", {16'd0, resp_z}, 32'h00FF);
    chk("hold_resp1_valid", {31'd0, resp1_valid}, 32'd0);

    // ---------------- reset during EXEC ----------------
    req0_valid = 1'b1;
    req0_op    = 2'b00;
    req0_x     = 16'hFFFF;
    req0_y     = 16'hFFFF;
    settle();
    chk("rmid_req0_ready", {31'd0, req0_ready}, 32'd1);
    step();
    req0_valid = 1'b0;
    rst        = 1'b1;
    step();
    rst = 1'b0;
    settle();
    chk("rmid_resp0_valid", {31'd0, resp0_valid}, 32'd0);
    chk("rmid_resp_z", {16'd0, resp_z}, 32'h0000);
    step();
    settle();
    chk("rmid_resp0_valid2", {31'd0, resp0_valid}, 32'd0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    settle();
    chk("rmid_prio_req0", {31'd0, req0_ready}, 32'd1);
    chk("rmid_prio_req1", {31'd0, req1_ready}, 32'd0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
`default_nettype wire
